// File: rtl/pattern_ctrl.sv
// rtl/pattern_ctrl.sv - 4-digit pattern loader and overlapping stream matcher with hit counter
// Optional sticky threshold interrupt is built only when MATCH_IRQ_EN is defined.
module pattern_ctrl #(
    parameter int CNT_W      = 8,
    parameter int IRQ_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_digit,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [3:0]       in_digit,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             irq,
    input  logic             irq_clr
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [3:0][3:0]    pat_q, pat_d;
    logic [3:0][3:0]    hist_q, hist_d;
    logic [3:0][3:0]    hist_new;
    logic [1:0]         idx_q, idx_d;
    logic [2:0]         hcnt_q, hcnt_d;
    logic [2:0]         hcnt_new;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               busy_q, busy_d;

    // index 0 is the oldest digit, so the newest sample enters at index 3
    assign hist_new = {in_digit, hist_q[3], hist_q[2], hist_q[1]};
    assign hcnt_new = (hcnt_q == 3'd4) ? 3'd4 : 3'(hcnt_q + 3'd1);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        idx_d   = idx_q;
        hcnt_d  = hcnt_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    pat_d[0] = cfg_digit;
                    idx_d    = 2'd1;
                    state_d  = LOAD;
                end else if (start) begin
                    hist_d  = '0;
                    hcnt_d  = 3'd0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (cfg_valid) begin
                    pat_d[idx_q] = cfg_digit;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = 2'(idx_q + 2'd1);
                    end
                end
            end
            RUN: begin
                // stop has priority: a coincident digit is dropped unsampled
                if (stop) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    hist_d = hist_new;
                    hcnt_d = hcnt_new;
                    if (hcnt_new == 3'd4 && hist_new == pat_q) begin
                        match_d = 1'b1;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cfg_ready_d = (state_d != RUN);
        busy_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pat_q       <= {4'd4, 4'd9, 4'd0, 4'd1};
            hist_q      <= '0;
            idx_q       <= 2'd0;
            hcnt_q      <= 3'd0;
            match_q     <= 1'b0;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            hist_q      <= hist_d;
            idx_q       <= idx_d;
            hcnt_q      <= hcnt_d;
            match_q     <= match_d;
            cnt_q       <= cnt_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;

`ifdef MATCH_IRQ_EN
    logic irq_q, irq_d;

    // set only on the increment that lands on the threshold; set beats clear
    always_comb begin
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (cnt_d != cnt_q && cnt_d == CNT_W'(IRQ_THRESH)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_clr | (IRQ_THRESH != 0);
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_ctrl.sv
// tb/tb_pattern_ctrl.sv - directed bench for pattern_ctrl (default and CNT_W=2 instances)
module tb_pattern_ctrl;

`ifdef MATCH_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic [3:0] cfg_digit;
    logic       start, stop, in_valid, irq_clr;
    logic [3:0] in_digit;

    logic       cfg_ready, match, busy, irq;
    logic [7:0] match_cnt;
    logic       cfg_ready2, match2, busy2, irq2;
    logic [1:0] match_cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pattern_ctrl #(.CNT_W(8), .IRQ_THRESH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_digit(cfg_digit), .cfg_ready(cfg_ready),
        .start(start), .stop(stop),
        .in_valid(in_valid), .in_digit(in_digit),
        .match(match), .match_cnt(match_cnt), .busy(busy),
        .irq(irq), .irq_clr(irq_clr)
    );

    pattern_ctrl #(.CNT_W(2), .IRQ_THRESH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_digit(cfg_digit), .cfg_ready(cfg_ready2),
        .start(start), .stop(stop),
        .in_valid(in_valid), .in_digit(in_digit),
        .match(match2), .match_cnt(match_cnt2), .busy(busy2),
        .irq(irq2), .irq_clr(irq_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_digit = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] d);
        cfg_valid = 1'b1;
        cfg_digit = d;
        step();
        cfg_valid = 1'b0;
    endtask

    logic [3:0] s1 [7] = '{4'd7, 4'd5, 4'd1, 4'd0, 4'd9, 4'd4, 4'd8};
    logic       m1 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] dflt [4] = '{4'd1, 4'd0, 4'd9, 4'd4};

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_digit = 4'd0;
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_digit = 4'd0; irq_clr = 1'b0;
        step(); step();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_match", match, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;
        step();

        // default pattern 1,0,9,4 inside a longer stream
        pulse_start();
        check("start_busy", busy, 1);
        check("start_cfg_ready", cfg_ready, 0);
        for (int i = 0; i < 7; i++) begin
            send(s1[i]);
            check($sformatf("s1_match_%0d", i), match, m1[i]);
        end
        check("s1_cnt", match_cnt, 1);
        check("s1_cnt2", match_cnt2, 1);

        pulse_stop();
        check("stop_busy", busy, 0);
        check("stop_cnt_held", match_cnt, 1);

        // in_valid gap before the final digit still matches
        pulse_start();
        check("restart_cnt_clr", match_cnt, 0);
        send(4'd1); send(4'd0); send(4'd9);
        step(); step(); step();
        check("gap_no_match", match, 0);
        send(4'd4);
        check("gap_match", match, 1);
        check("gap_cnt", match_cnt, 1);

        // stop coincident with the completing digit wins
        send(4'd1); send(4'd0); send(4'd9);
        stop = 1'b1; in_valid = 1'b1; in_digit = 4'd4;
        step();
        stop = 1'b0; in_valid = 1'b0;
        check("stopwin_match", match, 0);
        check("stopwin_busy", busy, 0);
        check("stopwin_cnt", match_cnt, 1);

        // load 2,2,2,2 with a gap and an ignored start inside LOAD
        cfg(4'd2); cfg(4'd2);
        check("load_cfg_ready", cfg_ready, 1);
        start = 1'b1; step(); start = 1'b0;
        check("load_start_ignored", busy, 0);
        step();
        cfg(4'd2); cfg(4'd2);
        check("load_done_ready", cfg_ready, 1);
        pulse_start();
        check("ovl_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            send(4'd2);
            check($sformatf("ovl_match_%0d", i), match, (i >= 3) ? 1 : 0);
        end
        check("ovl_cnt", match_cnt, 3);
        check("ovl_irq", irq, 0);
        pulse_stop();

        // partial load then reset restores the default pattern
        cfg(4'd3); cfg(4'd3);
        rst_n = 1'b0;
        #2;
        check("mid_rst_ready", cfg_ready, 1);
        check("mid_rst_cnt", match_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        for (int h = 1; h <= 5; h++) begin
            if (h == 5) begin
                irq_clr = 1'b1; step(); irq_clr = 1'b0;
                check("irq_cleared", irq, 0);
            end
            for (int k = 0; k < 3; k++) begin
                send(dflt[k]);
                check($sformatf("seq%0d_m%0d", h, k), match, 0);
            end
            send(dflt[3]);
            check($sformatf("seq%0d_match", h), match, 1);
            check($sformatf("seq%0d_cnt", h), match_cnt, h);
            check($sformatf("seq%0d_cnt2", h), match_cnt2, (h > 3) ? 3 : h);
            check($sformatf("seq%0d_irq", h), irq, (h == 4) ? IRQ_ON : 1'b0);
        end
        pulse_stop();
        check("end_busy", busy, 0);
        check("end_cnt_held", match_cnt, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
